mux_arb_nx: RTL
===============

# mux_arb_nx

Parametrised N-channel, WIDTH-bit arbitrating multiplexer with a registered output and valid/ready handshakes. It succeeds the fixed 4-way 32-bit combinational selector wherever several producers share one datapath sink, for example writeback-source or memory-port sharing in the CPU. Selection is made by an internal arbiter rather than an external select. The chosen item is held in a one-entry output register until the consumer accepts it.

## Interface
- WIDTH, 32, data width per channel
- N, 4, channel count (2..16)
- MODE, 1, 1 = round-robin, 0 = fixed priority (channel 0 highest)
- SW, derived as clog2(N), select-index width (localparam, not overridable)

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  N  per-channel request
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  N  one-hot-or-zero acceptance
- out_valid  out  1  output register holds an item
- out_data  out  WIDTH  registered selected data
- out_sel  out  SW  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts

## Operation
- Definitions:
  - `load = (!out_valid || out_ready) && |in_valid`.
  - `grant` is one-hot, computed combinationally from in_valid and the priority pointer `ptr` (SW bits).
- Round-robin: scan channels starting at ptr, then ptr+1, ..., wrapping mod N. The first valid channel wins.
- Fixed priority: the lowest-index valid channel wins. ptr is ignored and stays 0.
- `in_ready[i] = grant[i] && (!out_valid || out_ready)`. A transfer on channel i occurs when `in_valid[i] && in_ready[i]`.
- On load:
  - out_data <= selected in_data.
  - out_sel <= granted index.
  - out_valid <= 1.
  - In round-robin mode only, ptr <= (granted index + 1) mod N. For N not a power of two, wrap from N-1 to 0.
- When out_valid && out_ready && !load: out_valid <= 0. out_data and out_sel keep their values.
- When out_valid && !out_ready: all registers hold, in_ready is all-zero, and ptr does not move.
- Simultaneous accept and load in the same cycle: the new item replaces the old one, out_valid stays 1, and there is no bubble.
- Producers must hold in_valid and in_data until accepted. The arbiter may switch its grant while a producer waits, which is legal because nothing is accepted without in_ready.
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0.

## Timing
- Latency is 1 cycle from an input transfer to out_valid.
- Throughput is one item per cycle while out_ready=1.
- in_ready depends combinationally on in_valid, ptr, out_valid and out_ready. There is no combinational path from in_data to any output.
- rst asserted in any cycle takes priority over load and accept:
  - The next cycle shows reset values.
  - Any item held in the output register is dropped.
  - in_ready is all-zero during the reset cycle.

## Structure
- Shared package/include `mux_defs` holds:
  - the MODE_FIXED=0 and MODE_RR=1 constants;
  - the clog2 constant function used for SW.
- One sub-module, `rr_pick`. It is purely combinational.
  - Parameters: N, MODE.
  - Inputs: req[N], ptr[SW].
  - Outputs: grant[N], idx[SW], any.
  - It is instantiated once. mux_arb_nx owns all registers.

## Test plan
- Reset (N=4, WIDTH=32): hold rst 2 cycles with all inputs active -> out_valid=0, out_data=0, out_sel=0, in_ready=0000. After release, the first grant goes to channel 0.
- Round-robin fairness: all 4 valid with data 0xA0..0xA3, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data matches, one item per cycle.
- Backpressure: output holds 0xA1 with out_ready=0 for 3 cycles -> out_data/out_sel stable, in_ready=0000, ptr unchanged. On release -> the next item from channel 2 appears the following cycle.
- Sparse requests with wrap: ptr=3, only channel 2 valid with 0x55 -> grant channel 2, out_data=0x55, ptr becomes 3.
- Fixed priority (MODE=0): channels 1 and 3 valid continuously -> channel 1 is granted every cycle and channel 3 is never granted. Then drop channel 1 -> channel 3 is granted next.
- Non-power-of-two and mid-operation reset: N=3, all valid -> out_sel 0,1,2,0 with correct wrap. Assert rst while out_valid=1 -> out_valid=0 next cycle, and the next grant is channel 0.

Source files
------------

// File: rtl/mux_defs_pkg.sv
// Shared definitions for the arbitrating multiplexer.
//   MODE_FIXED / MODE_RR : arbitration mode selectors
//   clog2()              : constant function used to size select indices
package mux_defs;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Bits needed to index n items (n >= 2).
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational request picker.
//   req   : per-channel request vector
//   ptr   : highest-priority channel for round-robin (ignored in fixed mode)
//   grant : one-hot grant (all-zero when nothing requests)
//   idx   : binary index of the granted channel
//   any   : at least one request present
module rr_pick
  import mux_defs::*;
#(
  parameter int N    = 4,
  parameter int MODE = MODE_RR,
  localparam int SW  = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] idx,
  output logic          any
);

  int            start_idx;
  int            cand;
  logic [SW-1:0] cur;
  logic          found;

  // Scan from the start channel upward, wrapping at N; first requester wins.
  always_comb begin
    grant     = '0;
    idx       = '0;
    found     = 1'b0;
    cand      = 0;
    cur       = '0;
    start_idx = (MODE == MODE_RR) ? int'(ptr) : 0;
    for (int k = 0; k < N; k++) begin
      cand = start_idx + k;
      if (cand >= N) cand = cand - N;
      cur = SW'(cand);
      if (!found && req[cur]) begin
        found      = 1'b1;
        grant[cur] = 1'b1;
        idx        = cur;
      end
    end
    any = found;
  end

endmodule

// File: rtl/mux_arb_nx.sv
// N-channel arbitrating multiplexer with a one-entry registered output.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : per-channel request; producers hold it (and data) until accepted
//   in_data   : channel i on bits [i*WIDTH +: WIDTH]
//   in_ready  : one-hot-or-zero acceptance
//   out_valid : output register holds an item
//   out_data  : registered selected data
//   out_sel   : channel that supplied out_data
//   out_ready : consumer accepts
module mux_arb_nx
  import mux_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = MODE_RR,
  localparam int SW   = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_sel,
  input  logic                 out_ready
);

  logic [N-1:0]     grant;
  logic [SW-1:0]    idx;
  logic             any;
  logic             open;
  logic             load;
  logic [WIDTH-1:0] data_p0;
  logic [SW-1:0]    ptr_next;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SW-1:0]    sel_p1;
  logic [SW-1:0]    ptr_p1;

  // p0: arbitration and selection
  rr_pick #(
    .N    (N),
    .MODE (MODE)
  ) u_pick (
    .req   (in_valid),
    .ptr   (ptr_p1),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  // The output slot can take a new item if empty or being drained this cycle.
  assign open     = !vld_p1 || out_ready;
  assign load     = open && any;
  assign in_ready = (open && !rst) ? grant : '0;
  assign data_p0  = in_data[int'(idx)*WIDTH +: WIDTH];
  // Explicit wrap keeps non-power-of-two N inside 0..N-1.
  assign ptr_next = (int'(idx) == N - 1) ? '0 : idx + 1'b1;

  // p1: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      ptr_p1  <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_p0;
      sel_p1  <= idx;
      if (MODE == MODE_RR) ptr_p1 <= ptr_next;
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;

endmodule
